decode_stage: RTL and testbench

//  Registered RV32 decode pipeline stage between fetch and execute. Decodes inst into rs1/rs2/rd,

---
 rtl/decode_stage_pkg.sv | 79 +++++++
 rtl/decode_stage_comb.sv | 129 ++++++++++++
 rtl/decode_stage.sv | 144 ++++++++++++++
 tb/tb_decode_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// +----------------------------------------------------------------------------+
// | decode_stage_pkg : shared opcodes, ALU codes, flag indices, decode bundle  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package decode_stage_pkg;

  localparam logic [6:0] c_opc_lui      = 7'b0110111;
  localparam logic [6:0] c_opc_auipc    = 7'b0010111;
  localparam logic [6:0] c_opc_jal      = 7'b1101111;
  localparam logic [6:0] c_opc_jalr     = 7'b1100111;
  localparam logic [6:0] c_opc_branch   = 7'b1100011;
  localparam logic [6:0] c_opc_load     = 7'b0000011;
  localparam logic [6:0] c_opc_store    = 7'b0100011;
  localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
  localparam logic [6:0] c_opc_op       = 7'b0110011;
  localparam logic [6:0] c_opc_misc_mem = 7'b0001111;
  localparam logic [6:0] c_opc_system   = 7'b1110011;

  typedef enum logic [3:0] {
    c_alu_add  = 4'd0,
    c_alu_sub  = 4'd1,
    c_alu_sll  = 4'd2,
    c_alu_slt  = 4'd3,
    c_alu_sltu = 4'd4,
    c_alu_xor  = 4'd5,
    c_alu_srl  = 4'd6,
    c_alu_sra  = 4'd7,
    c_alu_or   = 4'd8,
    c_alu_and  = 4'd9
  } alu_ctrl_e;

  // Bit positions inside out_jbs_flags = {beq,bne,blt,bge,bltu,bgeu,jal,jalr,lui,auipc}
  localparam int c_jbs_beq   = 9;
  localparam int c_jbs_bne   = 8;
  localparam int c_jbs_blt   = 7;
  localparam int c_jbs_bge   = 6;
  localparam int c_jbs_bltu  = 5;
  localparam int c_jbs_bgeu  = 4;
  localparam int c_jbs_jal   = 3;
  localparam int c_jbs_jalr  = 2;
  localparam int c_jbs_lui   = 1;
  localparam int c_jbs_auipc = 0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu_ctrl;
    logic       alu_b_sel;
    logic       reg_w;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] wr_width;
    logic [9:0] jbs;
    logic       muldiv;
    logic       illegal;
  } dec_bundle_t;

  // alt selects SUB/SRA; callers only raise it where those forms are allowed
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? c_alu_sub : c_alu_add;
      3'b001:  op = c_alu_sll;
      3'b010:  op = c_alu_slt;
      3'b011:  op = c_alu_sltu;
      3'b100:  op = c_alu_xor;
      3'b101:  op = alt ? c_alu_sra : c_alu_srl;
      3'b110:  op = c_alu_or;
      default: op = c_alu_and;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_comb.sv
// +----------------------------------------------------------------------------+
// | decode_comb : pure combinational RV32 instruction -> decoded bundle        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EN_M = 0
) (
  input  logic [31:0]     inst_i,
  output dec_bundle_t     bundle_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm32;
  logic        w_legal;
  logic        w_is_md;
  dec_bundle_t w_dec;

  assign w_op = inst_i[6:0];
  assign w_f3 = inst_i[14:12];
  assign w_f7 = inst_i[31:25];

  assign w_imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign w_imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign w_imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_imm_u = {inst_i[31:12], 12'b0};
  assign w_imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    w_dec     = '0;
    w_imm32   = '0;
    w_legal   = 1'b1;
    w_is_md   = 1'b0;
    w_dec.rs1 = inst_i[19:15];
    w_dec.rs2 = inst_i[24:20];
    w_dec.rd  = inst_i[11:7];
    case (w_op)
      c_opc_lui: begin
        w_imm32               = w_imm_u;
        w_dec.jbs[c_jbs_lui]  = 1'b1;
      end
      c_opc_auipc: begin
        w_imm32                = w_imm_u;
        w_dec.jbs[c_jbs_auipc] = 1'b1;
      end
      c_opc_jal: begin
        w_imm32              = w_imm_j;
        w_dec.jbs[c_jbs_jal] = 1'b1;
      end
      c_opc_jalr: begin
        w_imm32               = w_imm_i;
        w_dec.jbs[c_jbs_jalr] = 1'b1;
      end
      c_opc_branch: begin
        w_imm32 = w_imm_b;
        case (w_f3)
          3'b000:  begin w_dec.jbs[c_jbs_beq]  = 1'b1; w_dec.alu_ctrl = c_alu_sub;  end
          3'b001:  begin w_dec.jbs[c_jbs_bne]  = 1'b1; w_dec.alu_ctrl = c_alu_sub;  end
          3'b100:  begin w_dec.jbs[c_jbs_blt]  = 1'b1; w_dec.alu_ctrl = c_alu_slt;  end
          3'b101:  begin w_dec.jbs[c_jbs_bge]  = 1'b1; w_dec.alu_ctrl = c_alu_slt;  end
          3'b110:  begin w_dec.jbs[c_jbs_bltu] = 1'b1; w_dec.alu_ctrl = c_alu_sltu; end
          3'b111:  begin w_dec.jbs[c_jbs_bgeu] = 1'b1; w_dec.alu_ctrl = c_alu_sltu; end
          default: w_legal = 1'b0;
        endcase
      end
      c_opc_load: begin
        w_imm32         = w_imm_i;
        w_dec.mem_rd    = 1'b1;
        w_dec.alu_b_sel = 1'b1;
        w_dec.wr_width  = w_f3;
        if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_legal = 1'b0;
      end
      c_opc_store: begin
        w_imm32         = w_imm_s;
        w_dec.mem_wr    = 1'b1;
        w_dec.alu_b_sel = 1'b1;
        w_dec.wr_width  = w_f3;
        if (w_f3 >= 3'b011) w_legal = 1'b0;
      end
      c_opc_op_imm: begin
        w_imm32         = w_imm_i;
        w_dec.alu_b_sel = 1'b1;
        w_dec.alu_ctrl  = alu_from_f3(w_f3, (w_f3 == 3'b101) && w_f7[5]);
        // Shift-immediates reuse imm[11:5] as a function field
        if (w_f3 == 3'b001 && w_f7 != 7'b0000000) w_legal = 1'b0;
        if (w_f3 == 3'b101 && w_f7 != 7'b0000000 && w_f7 != 7'b0100000) w_legal = 1'b0;
      end
      c_opc_op: begin
        case (w_f7)
          7'b0000000: w_dec.alu_ctrl = alu_from_f3(w_f3, 1'b0);
          7'b0100000: begin
            w_dec.alu_ctrl = alu_from_f3(w_f3, 1'b1);
            if (w_f3 != 3'b000 && w_f3 != 3'b101) w_legal = 1'b0;
          end
          7'b0000001: begin
            if (EN_M != 0) w_is_md = 1'b1;
            else           w_legal = 1'b0;
          end
          default: w_legal = 1'b0;
        endcase
      end
      c_opc_misc_mem,
      c_opc_system: w_imm32 = w_imm_i;
      default:      w_legal = 1'b0;
    endcase
    w_dec.muldiv = w_is_md;
    w_dec.reg_w  = (w_op != c_opc_store) && (w_op != c_opc_branch) &&
                   (w_op != c_opc_system) && (w_dec.rd != 5'd0);
    if (!w_legal) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
      w_imm32       = '0;
    end
  end

  assign bundle_o = w_dec;
  assign imm_o    = XLEN'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// +----------------------------------------------------------------------------+
// | decode_stage : registered RV32 decode stage with valid/ready + skid buffer |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int EN_M = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_ctrl,
  output logic            out_alu_b_sel,
  output logic            out_reg_w,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [2:0]      out_wr_width,
  output logic [9:0]      out_jbs_flags,
  output logic            out_muldiv,
  output logic            out_illegal
);

  dec_bundle_t     w_dec;
  logic [XLEN-1:0] w_imm;
  logic            w_accept;

  logic            out_valid_q, out_valid_d;
  dec_bundle_t     out_dec_q,   out_dec_d;
  logic [XLEN-1:0] out_imm_q,   out_imm_d;
  logic [PC_W-1:0] out_pc_q,    out_pc_d;
  logic            skid_valid_q, skid_valid_d;
  dec_bundle_t     skid_dec_q,   skid_dec_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
  logic [PC_W-1:0] skid_pc_q,    skid_pc_d;
  logic            in_ready_q,   in_ready_d;

  decode_comb #(
    .XLEN (XLEN),
    .EN_M (EN_M)
  ) u_decode_comb (
    .inst_i   (in_inst),
    .bundle_o (w_dec),
    .imm_o    (w_imm)
  );

  assign w_accept = in_valid && in_ready_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_dec_d    = out_dec_q;
    out_imm_d    = out_imm_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_dec_d   = skid_dec_q;
    skid_imm_d   = skid_imm_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees this cycle: the older skid entry goes first
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_dec_d    = skid_dec_q;
        out_imm_d    = skid_imm_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        out_valid_d = 1'b1;
        out_dec_d   = w_dec;
        out_imm_d   = w_imm;
        out_pc_d    = in_pc;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_dec_d   = w_dec;
      skid_imm_d   = w_imm;
      skid_pc_d    = in_pc;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_dec_q    <= '0;
      out_imm_q    <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_dec_q   <= '0;
      skid_imm_q   <= '0;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_dec_q    <= out_dec_d;
      out_imm_q    <= out_imm_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_dec_q   <= skid_dec_d;
      skid_imm_q   <= skid_imm_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_imm       = out_imm_q;
  assign out_rs1       = out_dec_q.rs1;
  assign out_rs2       = out_dec_q.rs2;
  assign out_rd        = out_dec_q.rd;
  assign out_alu_ctrl  = out_dec_q.alu_ctrl;
  assign out_alu_b_sel = out_dec_q.alu_b_sel;
  assign out_reg_w     = out_dec_q.reg_w;
  assign out_mem_rd    = out_dec_q.mem_rd;
  assign out_mem_wr    = out_dec_q.mem_wr;
  assign out_wr_width  = out_dec_q.wr_width;
  assign out_jbs_flags = out_dec_q.jbs;
  assign out_muldiv    = out_dec_q.muldiv;
  assign out_illegal   = out_dec_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// +----------------------------------------------------------------------------+
// | tb_decode_stage : self-checking bench, EN_M=0 and EN_M=1 side by side      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready[2], out_valid[2];
  logic [31:0] out_pc[2], out_imm[2];
  logic [4:0]  out_rs1[2], out_rs2[2], out_rd[2];
  logic [3:0]  out_alu_ctrl[2];
  logic        out_alu_b_sel[2], out_reg_w[2], out_mem_rd[2], out_mem_wr[2];
  logic [2:0]  out_wr_width[2];
  logic [9:0]  out_jbs_flags[2];
  logic        out_muldiv[2], out_illegal[2];

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } item_t;
  item_t q[$];

  logic [3:0] alu_tab[8];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32), .EN_M(0)) u_dut_m0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_pc(out_pc[0]), .out_rs1(out_rs1[0]), .out_rs2(out_rs2[0]), .out_rd(out_rd[0]),
    .out_imm(out_imm[0]), .out_alu_ctrl(out_alu_ctrl[0]), .out_alu_b_sel(out_alu_b_sel[0]),
    .out_reg_w(out_reg_w[0]), .out_mem_rd(out_mem_rd[0]), .out_mem_wr(out_mem_wr[0]),
    .out_wr_width(out_wr_width[0]), .out_jbs_flags(out_jbs_flags[0]),
    .out_muldiv(out_muldiv[0]), .out_illegal(out_illegal[0])
  );

  decode_stage #(.XLEN(32), .PC_W(32), .EN_M(1)) u_dut_m1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_pc(out_pc[1]), .out_rs1(out_rs1[1]), .out_rs2(out_rs2[1]), .out_rd(out_rd[1]),
    .out_imm(out_imm[1]), .out_alu_ctrl(out_alu_ctrl[1]), .out_alu_b_sel(out_alu_b_sel[1]),
    .out_reg_w(out_reg_w[1]), .out_mem_rd(out_mem_rd[1]), .out_mem_wr(out_mem_wr[1]),
    .out_wr_width(out_wr_width[1]), .out_jbs_flags(out_jbs_flags[1]),
    .out_muldiv(out_muldiv[1]), .out_illegal(out_illegal[1])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {rs1,rs2,rd,imm,alu,b_sel,reg_w,mem_rd,mem_wr,width,jbs,muldiv,illegal}
  function automatic logic [69:0] get_obs(input int k);
    return {out_rs1[k], out_rs2[k], out_rd[k], out_imm[k], out_alu_ctrl[k], out_alu_b_sel[k],
            out_reg_w[k], out_mem_rd[k], out_mem_wr[k], out_wr_width[k], out_jbs_flags[k],
            out_muldiv[k], out_illegal[k]};
  endfunction

  function automatic logic [69:0] ref_dec(input logic [31:0] w, input bit en_m);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [2:0]  wid;
    logic [9:0]  jbs;
    bit          bad, bsel, mr, mw, md, wr;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    imm = 0; alu = c_alu_add; wid = 0; jbs = 0;
    bsel = 0; mr = 0; mw = 0; md = 0;
    bad = !(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                       7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011});
    if (w[1:0] != 2'b11 || w == 32'd0) bad = 1;
    if (op == 7'b0110111 || op == 7'b0010111) imm = w & 32'hFFFF_F000;
    if (op inside {7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011})
      imm = 32'($signed(w[31:20]));
    if (op == 7'b0100011) imm = 32'($signed({w[31:25], w[11:7]}));
    if (op == 7'b1100011) imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    if (op == 7'b1101111) imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    if (op == 7'b0110111) jbs = 10'd2;
    if (op == 7'b0010111) jbs = 10'd1;
    if (op == 7'b1101111) jbs = 10'd8;
    if (op == 7'b1100111) jbs = 10'd4;
    if (op == 7'b1100011) begin
      case (f3)
        0: begin jbs = 10'b1000000000; alu = c_alu_sub;  end
        1: begin jbs = 10'b0100000000; alu = c_alu_sub;  end
        4: begin jbs = 10'b0010000000; alu = c_alu_slt;  end
        5: begin jbs = 10'b0001000000; alu = c_alu_slt;  end
        6: begin jbs = 10'b0000100000; alu = c_alu_sltu; end
        7: begin jbs = 10'b0000010000; alu = c_alu_sltu; end
        default: bad = 1;
      endcase
    end
    if (op == 7'b0000011) begin
      mr = 1; bsel = 1; wid = f3;
      if (f3 == 3 || f3 >= 6) bad = 1;
    end
    if (op == 7'b0100011) begin
      mw = 1; bsel = 1; wid = f3;
      if (f3 >= 3) bad = 1;
    end
    if (op == 7'b0010011) begin
      bsel = 1;
      alu = alu_tab[f3];
      if (f3 == 1 && f7 != 0) bad = 1;
      if (f3 == 5 && f7 != 0 && f7 != 7'h20) bad = 1;
      if (f3 == 5 && f7 == 7'h20) alu = c_alu_sra;
    end
    if (op == 7'b0110011) begin
      if (f7 == 7'h01) begin
        if (en_m) md = 1;
        else bad = 1;
      end else if (f7 == 7'h00) begin
        alu = alu_tab[f3];
      end else if (f7 == 7'h20 && f3 == 0) begin
        alu = c_alu_sub;
      end else if (f7 == 7'h20 && f3 == 5) begin
        alu = c_alu_sra;
      end else begin
        bad = 1;
      end
    end
    wr = !(op inside {7'b0100011, 7'b1100011, 7'b1110011}) && (w[11:7] != 0);
    if (bad) return 70'd1;
    return {w[19:15], w[24:20], w[11:7], imm, alu, bsel, wr, mr, mw, wid, jbs, md, 1'b0};
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("m%0d_in_ready", k), in_ready[k], q.size() < 2);
      check($sformatf("m%0d_out_valid", k), out_valid[k], q.size() > 0);
      if (q.size() > 0) begin
        check($sformatf("m%0d_bundle_%08h", k, q[0].inst), get_obs(k), ref_dec(q[0].inst, k == 1));
        check($sformatf("m%0d_pc", k), out_pc[k], q[0].pc);
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge
  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    int sz;
    check_outputs();
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
    @(posedge clk);
    sz = q.size();
    if (fl) begin
      q.delete();
    end else begin
      if (sz > 0 && ordy) void'(q.pop_front());
      if (v && sz < 2) q.push_back('{inst: inst, pc: pc});
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] gen_inst();
    logic [6:0] ops[12];
    logic [6:0] f7s[4];
    int r;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011, 7'b1011011};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h00};
    f7s[3] = 7'($urandom);
    r = $urandom_range(0, 15);
    if (r == 0) return $urandom;
    if (r == 1) return 32'd0;
    return {f7s[$urandom_range(0, 3)], 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom),
            ops[$urandom_range(0, 11)]};
  endfunction

  initial begin
    alu_tab = '{c_alu_add, c_alu_sll, c_alu_slt, c_alu_sltu,
                c_alu_xor, c_alu_srl, c_alu_or, c_alu_and};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", out_valid[k], 0);
      check("rst_in_ready", in_ready[k], 1);
      check("rst_bundle", get_obs(k), 0);
      check("rst_pc", out_pc[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // add x3,x1,x2
    step(1, 32'h002081B3, 32'h100, 1, 0);
    check("add_rd", out_rd[0], 3);
    check("add_rs1", out_rs1[0], 1);
    check("add_rs2", out_rs2[0], 2);
    check("add_alu", out_alu_ctrl[0], c_alu_add);
    check("add_reg_w", out_reg_w[0], 1);
    check("add_b_sel", out_alu_b_sel[0], 0);
    // lw x5,-4(x2)
    step(1, 32'hFFC12283, 32'h104, 1, 0);
    check("lw_imm", out_imm[0], 32'hFFFF_FFFC);
    check("lw_mem_rd", out_mem_rd[0], 1);
    check("lw_width", out_wr_width[0], 3'b010);
    check("lw_b_sel", out_alu_b_sel[0], 1);
    check("lw_reg_w", out_reg_w[0], 1);
    step(0, 0, 0, 1, 0);

    // Backpressure: third instruction must wait until the skid drains
    step(1, 32'h00100093, 32'h200, 0, 0);
    step(1, 32'h00200113, 32'h204, 0, 0);
    check("bp_in_ready_low", in_ready[0], 0);
    step(1, 32'h00300193, 32'h208, 1, 0);
    check("bp_in_ready_back", in_ready[0], 1);
    step(1, 32'h00300193, 32'h208, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Flush with both slots full
    step(1, 32'h00100093, 32'h300, 0, 0);
    step(1, 32'h00200113, 32'h304, 0, 0);
    step(1, 32'h00300193, 32'h308, 0, 1);
    check("flush_out_valid", out_valid[0], 0);
    check("flush_in_ready", in_ready[0], 1);
    step(1, 32'h00400213, 32'h30C, 1, 0);
    check("post_flush_pc", out_pc[0], 32'h30C);
    step(0, 0, 0, 1, 0);

    // mul x1,x2,x3 on both variants
    step(1, 32'h023100B3, 32'h400, 1, 0);
    check("mul_m0_illegal", out_illegal[0], 1);
    check("mul_m0_reg_w", out_reg_w[0], 0);
    check("mul_m1_muldiv", out_muldiv[1], 1);
    check("mul_m1_illegal", out_illegal[1], 0);
    step(1, 32'h00000000, 32'h404, 1, 0);
    check("zero_illegal", out_illegal[0], 1);
    step(1, 32'h00002063, 32'h408, 1, 0);
    check("bne_f3_010_illegal", out_illegal[0], 1);

    // Asynchronous reset between clock edges with both slots full
    step(1, 32'h00100093, 32'h500, 0, 0);
    step(1, 32'h00200113, 32'h504, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("async_rst_out_valid", out_valid[k], 0);
      check("async_rst_in_ready", in_ready[k], 1);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, gen_inst(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
